// File: rtl/riscv_enc_pkg.sv
// Shared encoding constants for instr_encoder: format codes, opcodes, immediate limits, FIFO entry.
// Pure definitions; no latency or backpressure of its own.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_LOAD   = 3'd1,
    FMT_OPIMM  = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_BRANCH = 3'd4
  } fmt_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
  localparam logic signed [63:0] IMM12_MAX =  64'sd2047;
  localparam logic signed [63:0] BIMM_MIN  = -64'sd4096;
  localparam logic signed [63:0] BIMM_MAX  =  64'sd4094;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
  } entry_t;

endpackage

// File: rtl/enc_fifo.sv
// Generic synchronous FIFO, valid/ready on both sides; a push is visible at the head one edge later.
// push_rdy depends only on occupancy, so a pop in the same cycle does not admit a push into a full FIFO.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign push_rdy = (count != FULL_CNT);
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV64 field sets into 32-bit words tagged with a running byte address, queued in enc_fifo.
// Accepted word is at the head one edge later; in_ready follows FIFO space, rejects pulse err next cycle.
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  fmt_e               fmt;
  logic signed [63:0] imm_s;
  logic [31:0]        word;
  logic               fmt_ok, imm_ok;
  logic               accept, push_vld, reject;
  logic [63:0]        addr;
  entry_t             push_dat, pop_dat;

  assign fmt   = fmt_e'(in_fmt);
  assign imm_s = signed'(in_imm);

  always_comb begin
    word   = '0;
    fmt_ok = 1'b1;
    imm_ok = 1'b1;
    case (fmt)
      FMT_R: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      FMT_LOAD, FMT_OPIMM: begin
        word   = {in_imm[11:0], in_rs1, in_funct3, in_rd,
                  (fmt == FMT_LOAD) ? OP_LOAD : OP_OPIMM};
        imm_ok = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
      end
      FMT_STORE: begin
        word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        imm_ok = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
      end
      FMT_BRANCH: begin
        word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], OP_BRANCH};
        // Branch offsets are halfword-aligned; an odd offset is unencodable.
        imm_ok = (imm_s >= BIMM_MIN) && (imm_s <= BIMM_MAX) && !in_imm[0];
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign push_vld = accept && fmt_ok && imm_ok;
  assign reject   = accept && !(fmt_ok && imm_ok);
  assign push_dat = '{instr: word, addr: addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= reject;
      if (reject && err_count != 8'hFF) err_count <= err_count + 1'b1;
      if (push_vld) addr <= addr + 64'd4;
    end
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_rdy (in_ready),
    .push_dat (push_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (pop_dat)
  );

  assign out_instr = pop_dat.instr;
  assign out_addr  = pop_dat.addr;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: the driver queues hand-computed {word, address} pairs,
// a free-running monitor pops and compares them on every output handshake.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        err;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;
  int exp_errs = 0;
  logic [95:0] exp_q [$];

  instr_encoder #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver has settled its negedge updates.
  always begin
    @(negedge clk);
    #3;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h_%0h expected=none", out_instr, out_addr);
      end else begin
        chk("out_word_addr", {out_instr, out_addr}, exp_q.pop_front());
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [63:0] imm, input logic bad, input logic [31:0] ei,
                      input logic [63:0] ea, output int waited);
    logic got;
    got = 1'b0;
    waited = 0;
    in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (in_ready) begin
        got = 1'b1;
        if (!bad) exp_q.push_back({ei, ea});
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept");
    end else if (bad) begin
      if (exp_errs < 255) exp_errs++;
      chk("err_pulse", {95'd0, err}, 96'd1);
      chk("err_count", {88'd0, err_count}, 96'(exp_errs));
    end else begin
      chk("err_quiet", {95'd0, err}, 96'd0);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    #4;
    chk("drained", 96'(exp_q.size()), 96'd0);
    chk("out_valid_empty", {95'd0, out_valid}, 96'd0);
  endtask

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
    chk("rst_err", {95'd0, err}, 96'd0);
    chk("rst_err_count", {88'd0, err_count}, 96'd0);

    // fmt rd rs1 rs2 f3 f7 imm bad word addr
    send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1,  1'b0, 32'h00100003, 64'd0, w);
    send(3'd3, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 64'd2,  1'b0, 32'h00112123, 64'd4, w);
    send(3'd4, 5'd0, 5'd2, 5'd1, 3'd0, 7'd0, -64'd4, 1'b0, 32'hFE110EE3, 64'd8, w);
    send(3'd4, 5'd0, 5'd2, 5'd1, 3'd0, 7'd0, 64'd3,  1'b1, 32'h0, 64'd0, w);
    // R ignores the immediate entirely, even a wildly out-of-range one.
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'h8000_0000_0000_0000, 1'b0, 32'h002081B3, 64'd12, w);
    send(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2047, 1'b0, 32'h7FF00093, 64'd16, w);
    send(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, 1'b1, 32'h0, 64'd0, w);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'd2048, 1'b0, 32'h80000023, 64'd20, w);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'd2049, 1'b1, 32'h0, 64'd0, w);
    send(3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0,  1'b1, 32'h0, 64'd0, w);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'd4096, 1'b0, 32'h80000063, 64'd24, w);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4096, 1'b1, 32'h0, 64'd0, w);
    send(3'd1, 5'd5, 5'd6, 5'd0, 3'd3, 7'd0, 64'd8, 1'b0, 32'h00833283, 64'd28, w);
    wait_drain();

    // Saturation: push the reject count well past 255.
    for (int i = 0; i < 252; i++)
      send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b1, 32'h0, 64'd0, w);
    chk("err_count_sat", {88'd0, err_count}, 96'd255);

    // Backpressure and full-FIFO simultaneous push/pop, from a clean address.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; exp_errs = 0; out_ready = 1'b0;
    send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 1'b0, 32'h00100003, 64'd0, w);
    send(3'd3, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 64'd2, 1'b0, 32'h00112123, 64'd4, w);
    for (int i = 0; i < 3; i++) begin
      chk("full_in_ready", {95'd0, in_ready}, 96'd0);
      chk("stall_head", {out_instr, out_addr}, {32'h00100003, 64'd0});
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1'b0, 32'h002081B3, 64'd8, w);
    chk("full_pop_only_wait", 96'(w), 96'd1);
    wait_drain();

    // Reset with two entries queued discards them and rewinds the address.
    out_ready = 1'b0;
    send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 1'b0, 32'h00100003, 64'd12, w);
    send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 1'b0, 32'h00100003, 64'd16, w);
    chk("queued_out_valid", {95'd0, out_valid}, 96'd1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("midrst_in_ready", {95'd0, in_ready}, 96'd1);
    chk("midrst_err_count", {88'd0, err_count}, 96'd0);
    out_ready = 1'b1;
    send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 1'b0, 32'h00100003, 64'd0, w);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request carries a field set to encode.
REQ-005 SHALL have port in_ready  output  1  encoder accepts a request this cycle.
REQ-006 SHALL have port in_fmt  input  3  format: 0=R(0110011), 1=LOAD(0000011), 2=OPIMM(0010011), 3=STORE(0100011), 4=BRANCH(1100011), 5-7 illegal.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 SHALL have ports in_funct3  input  3 and in_funct7  input  7  function fields.
REQ-009 SHALL have port in_imm  input  64  signed immediate, byte offset for BRANCH.
REQ-010 SHALL have port out_valid  output  1  head FIFO entry present.
REQ-011 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-012 SHALL have ports out_instr  output  32 and out_addr  output  64  encoded word and its byte address.
REQ-013 SHALL have port err  output  1  one-cycle pulse, rejected request.
REQ-014 SHALL have port err_count  output  8  saturating count of rejected requests.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-016 SHALL drive in_ready = FIFO not full; a pop in the same cycle does not free space for that cycle's accept.
REQ-017 SHALL pack R as {funct7,rs2,rs1,funct3,rd,op} and LOAD/OPIMM as {imm[11:0],rs1,funct3,rd,op}.
REQ-018 SHALL pack STORE as {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
REQ-019 SHALL pack BRANCH as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
REQ-020 SHALL treat in_imm as out of range when it is outside -2048..2047 for LOAD, OPIMM and STORE.
REQ-021 SHALL treat in_imm as out of range for BRANCH when it is outside -4096..4094 or odd; the immediate is ignored for R.
REQ-022 SHALL, for an accepted request with illegal in_fmt or out-of-range in_imm, write no FIFO entry and leave the address unchanged.
REQ-023 SHALL, for such a rejected request, pulse err in the following cycle and increment err_count, saturating at 255.
REQ-024 SHALL keep a 64-bit address counter: a legal accepted request stores the counter value with its word, then the counter advances by 4, wrapping modulo 2^64.
REQ-025 SHALL present a legal word accepted at edge N on out_valid/out_instr/out_addr from edge N, in FIFO order, once the entries ahead of it have been popped.
REQ-026 SHALL pop the head entry on an edge where out_valid && out_ready.
REQ-027 SHALL hold out_instr and out_addr stable while out_valid && !out_ready.
REQ-028 SHALL handle a simultaneous push and pop correctly at any occupancy, including a full FIFO, where only the pop occurs.
REQ-029 SHALL show out_instr and out_addr as don't-care when out_valid = 0.

Reset
REQ-030 SHALL, while reset is high at an edge, clear FIFO pointers and occupancy, the address counter, err and err_count to 0, so out_valid=0 and in_ready=1 after that edge.
REQ-031 SHALL discard FIFO contents and any in-flight err pulse on a reset asserted mid-operation; a request presented during reset is not accepted.

Structure
REQ-032 SHALL take the format codes, the five opcode constants and the immediate range limits from a shared package, riscv_enc_pkg.
REQ-033 SHALL instantiate one sub-module, enc_fifo, a parameterised synchronous FIFO with valid/ready on both sides.
REQ-034 SHALL keep the packing and range checks combinational ahead of the FIFO push.

Verification
REQ-035 SHALL test reset: after reset, LOAD rd=0 rs1=0 f3=0 imm=1 -> out_instr=0x00100003, out_addr=0; then STORE rs1=2 rs2=1 f3=2 imm=2 -> 0x00112123, out_addr=4.
REQ-036 SHALL test BRANCH rs1=2 rs2=1 f3=0 imm=-4 -> out_instr=0xFE110EE3; BRANCH imm=3 -> err pulse, err_count=1, no entry, next legal word keeps the prior address+4.
REQ-037 SHALL test range limits: OPIMM imm=2047 is accepted and imm=2048 is rejected; STORE imm=-2048 is accepted and imm=-2049 is rejected.
REQ-038 SHALL test backpressure: out_ready=0 with 3 legal requests -> in_ready drops after 2, head stable; out_ready=1 -> words drain in order with addresses 0,4,8.
REQ-039 SHALL test full FIFO with simultaneous in_valid and out_ready -> pop only, third request accepted the next cycle.
REQ-040 SHALL test reset asserted with 2 entries queued -> out_valid=0 next cycle; next legal word has out_addr=0.
